// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch queue slice.
// Optional build macro: FETCH_PERF_EN (adds saturating performance counters).
package fetch_pkg;

    localparam int          XLEN_DEF       = 32;
    localparam logic [31:0] RESET_INSN_DEF = 32'h0000_0000;

    // One queued fetch: the pc it came from and the returned word.
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] insn;
    } fetch_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory request/response and decode handshake bundle of the fetch queue.
// master = fetch unit, slave = surrounding memory/decode/execute.
// Optional build macro: FETCH_PERF_EN (adds perf_* counter outputs).
interface fetch_queue_if #(parameter int XLEN = fetch_pkg::XLEN_DEF);

    logic            override;
    logic [XLEN-1:0] newpc;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] outpc;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_flushes;
    logic [31:0]     perf_dropped;
`endif

    modport master (
        input  override, newpc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output mem_req_valid, mem_addr, out_valid, instruction, outpc
`ifdef FETCH_PERF_EN
        , output perf_fetched, perf_flushes, perf_dropped
`endif
    );

    modport slave (
        output override, newpc, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  mem_req_valid, mem_addr, out_valid, instruction, outpc
`ifdef FETCH_PERF_EN
        , input perf_fetched, perf_flushes, perf_dropped
`endif
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with single-cycle flush.
// Overflow/underflow protection is left to the caller (credit-based issue).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Storage write; contents need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: issues in-order memory requests under a credit
// limit of DEPTH, queues responses and hands them to decode via valid/ready.
// A redirect (override) flushes the queue and drops responses still in flight.
// Optional build macro: FETCH_PERF_EN adds saturating pop/flush/drop counters.
// XLEN must match fetch_pkg::XLEN_DEF since queue entries use the package struct.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN              = XLEN_DEF,
    parameter int              DEPTH             = 4,
    parameter logic [XLEN-1:0] RESET_PC          = '0,
    parameter logic [XLEN-1:0] RESET_INSTRUCTION = RESET_INSN_DEF
) (
    input logic           clk,
    input logic           rstn,
    fetch_queue_if.master bus
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic            fire;
    logic            rsp_take;
    logic            push;
    logic            discard;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign credit            = {1'b0, count} + {1'b0, outstanding};
    assign bus.mem_req_valid = rstn && !bus.override && (credit < DEPTH_W);
    assign bus.mem_addr      = pc;
    assign fire              = bus.mem_req_valid && bus.mem_req_ready;

    // Responses with nothing outstanding are stale (e.g. from before a reset).
    assign rsp_take = bus.mem_rsp_valid && (outstanding != '0);
    assign push     = rsp_take && !bus.override && (drop == '0);
    assign discard  = rsp_take && (bus.override || (drop != '0));

    assign push_entry.pc   = rsp_pc;
    assign push_entry.insn = bus.mem_rsp_data;

    assign bus.out_valid   = (count != '0) && !bus.override;
    assign pop             = bus.out_valid && bus.out_ready;
    assign bus.instruction = (count != '0) ? head.insn : RESET_INSTRUCTION;
    assign bus.outpc       = (count != '0) ? head.pc   : rsp_pc;

    fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (bus.override),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Request/response pc tracking and in-flight accounting; redirect drops
    // every request still outstanding after this cycle's response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (bus.override) begin
            pc          <= {bus.newpc[XLEN-1:2], 2'b00};
            rsp_pc      <= {bus.newpc[XLEN-1:2], 2'b00};
            outstanding <= outstanding - CW'(rsp_take);
            drop        <= outstanding - CW'(rsp_take);
        end else begin
            if (fire) pc     <= pc + XLEN'(4);
            if (push) rsp_pc <= rsp_pc + XLEN'(4);
            outstanding <= outstanding + CW'(fire) - CW'(rsp_take);
            if (discard) drop <= drop - CW'(1);
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushes;
    logic [31:0] perf_dropped;

    assign bus.perf_fetched = perf_fetched;
    assign bus.perf_flushes = perf_flushes;
    assign bus.perf_dropped = perf_dropped;

    // Saturating event counters for pops, redirect cycles and discarded words.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= sat_inc(perf_fetched, pop);
            perf_flushes <= sat_inc(perf_flushes, bus.override);
            perf_dropped <= sat_inc(perf_dropped, discard);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a behavioural memory plus epoch-based
// reference model feeds an expected-instruction queue; a separate monitor
// checks every decode pop against it.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] RST_INSN = 32'h0000_0000;

    typedef struct {
        int          due;
        int          epoch;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC), .RESET_INSTRUCTION(RST_INSN)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    logic [31:0] m_addr = RST_PC;
    logic [31:0] m_rsp_pc = RST_PC;
    pend_t       pend[$];
    exp_t        exp_q[$];
    int          m_fetched = 0;
    int          m_flushes = 0;
    int          m_dropped = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs at negedge, then check and advance the model.
    task automatic cycle(input logic rst, input logic ovr, input logic [31:0] npc,
                         input int rr_pct, input int or_pct, input int lat, input logic inject);
        logic  from_mem;
        logic  exp_ov;
        pend_t e;
        int    due;
        @(negedge clk);
        rstn              = !rst;
        bus.override      = ovr;
        bus.newpc         = npc;
        bus.mem_req_ready = ($urandom_range(99) < rr_pct);
        bus.out_ready     = rst ? 1'b0 : ($urandom_range(99) < or_pct);
        from_mem          = 1'b0;
        if (inject) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = $urandom;
        end else if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_word(pend[0].addr);
            from_mem          = 1'b1;
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = $urandom;
        end
        #1;
        if (rst) begin
            pend.delete();
            exp_q.delete();
            epoch++;
            m_addr    = RST_PC;
            m_rsp_pc  = RST_PC;
            last_due  = cyc;
            m_fetched = 0;
            m_flushes = 0;
            m_dropped = 0;
        end else begin
            exp_ov = !ovr && (exp_q.size() != 0);
            check("mem_req_valid", bus.mem_req_valid,
                  !ovr && (exp_q.size() + pend.size() < DEPTH));
            check("out_valid", bus.out_valid, exp_ov);
            if (exp_q.size() == 0) begin
                check("idle_instruction", bus.instruction, RST_INSN);
                check("idle_outpc", bus.outpc, m_rsp_pc);
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                check("mem_addr", bus.mem_addr, m_addr);
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = due;
                pend.push_back('{due: due, epoch: epoch, addr: m_addr});
                m_addr += 32'd4;
            end
            if (from_mem) begin
                e = pend.pop_front();
                if (e.epoch == epoch && !ovr) begin
                    exp_q.push_back('{pc: m_rsp_pc, insn: mem_word(e.addr)});
                    m_rsp_pc += 32'd4;
                end else begin
                    m_dropped++;
                end
            end
            if (exp_ov && bus.out_ready) m_fetched++;
            if (ovr) begin
                exp_q.delete();
                epoch++;
                m_addr   = {npc[31:2], 2'b00};
                m_rsp_pc = {npc[31:2], 2'b00};
                m_flushes++;
            end
        end
        cyc++;
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_EN
        check("perf_fetched", bus.perf_fetched, m_fetched);
        check("perf_flushes", bus.perf_flushes, m_flushes);
        check("perf_dropped", bus.perf_dropped, m_dropped);
`endif
    endtask

    // Monitor: every decode pop must match the head of the expected queue.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pop_unexpected actual=pc %h expected=no entry cycle=%0d",
                             bus.outpc, cyc);
                end else begin
                    x = exp_q.pop_front();
                    check("pop_outpc", bus.outpc, x.pc);
                    check("pop_instruction", bus.instruction, x.insn);
                end
            end
        end
    end

    initial begin
        bus.override      = 1'b0;
        bus.newpc         = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.out_ready     = 1'b0;

        // Reset, then reset-state outputs with memory stalled.
        repeat (2) cycle(1, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_outpc", bus.outpc, RST_PC);
        check("reset_mem_addr", bus.mem_addr, RST_PC);
        check_perf();

        // 1-cycle memory, decode always ready.
        repeat (20) cycle(0, 0, 0, 100, 100, 1, 0);

        // Decode stalled: credits run out after DEPTH outstanding+queued.
        repeat (10) cycle(0, 0, 0, 100, 0, 1, 0);
        check("stall_req_valid", bus.mem_req_valid, 1'b0);
        check("stall_out_valid", bus.out_valid, 1'b1);
        repeat (12) cycle(0, 0, 0, 100, 100, 1, 0);

        // Latency 3 with requests in flight, then redirect to 0x100.
        repeat (10) cycle(0, 0, 0, 100, 100, 3, 0);
        cycle(0, 1, 32'h0000_0100, 100, 100, 3, 0);
        repeat (15) cycle(0, 0, 0, 100, 100, 3, 0);
        check_perf();

        // Misaligned redirect with a response landing in the override cycle.
        repeat (6) cycle(0, 0, 0, 100, 100, 1, 0);
        cycle(0, 1, 32'h0000_0203, 100, 100, 1, 0);
        repeat (10) cycle(0, 0, 0, 100, 100, 1, 0);

        // Randomised handshakes, latencies and occasional redirects.
        for (int i = 0; i < 1000; i++) begin
            cycle(0, ($urandom_range(99) < 3), $urandom, 70, 60, $urandom_range(4, 1), 0);
        end
        check_perf();

        // Reset mid-stream, stale responses while nothing is outstanding.
        repeat (5) cycle(0, 0, 0, 100, 50, 3, 0);
        cycle(1, 0, 0, 0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0, 100, 1, 1);
        repeat (40) cycle(0, 0, 0, 80, 70, $urandom_range(3, 1), 0);
        check_perf();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
